muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle controller for the RV32M operations (Class 4, SELOperation 24–31) in the processor's execute stage. It accepts one operation at a time from the ALU control path and runs an iterative radix-2 shift-add multiply or restoring divide over 32 cycles. While it runs it stalls the pipeline, then returns the 32-bit result with a one-cycle done pulse. Single-cycle base ALU operations never enter this block.

## Interface
- `XLEN`, default 32: operand and result width; only 32 is supported.
- `clk` input 1: system clock; everything is rising-edge.
- `rst_n` input 1: reset; one clock, synchronous, active-low.
- `start` input 1: request; sampled only in IDLE.
- `sel_operation` input 5: SELOperation code from ALU control; an op is valid only when bits [4:3] are 2'b11, and bits [2:0] select the op.
- `flush` input 1: pipeline kill; aborts any operation in flight.
- `operand_a` input 32: rs1 value, latched when start is accepted.
- `operand_b` input 32: rs2 value, latched when start is accepted.
- `busy` output 1: high whenever state is not IDLE.
- `stall` output 1: high when `busy` is high, or when `start` is accepted this cycle.
- `done` output 1: high for exactly one cycle, in DONE.
- `result` output 32: final value; held stable from DONE until the next accepted start.

## Operation
- Op encoding (bits [2:0]): 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Start is accepted when `start`=1, state is IDLE, `sel_operation[4:3]`=2'b11 and `flush`=0.
  - Any other code, including IDLE code 16, is ignored.
  - `start` while busy is ignored; it is not queued.
- FSM states: IDLE → PREP → CALC → FIX → DONE → IDLE.
- PREP:
  - Convert the signed operands to magnitudes and record the result sign.
  - MULHSU treats only `operand_a` as signed.
  - MUL, MULHU, DIVU, REMU and the unsigned operand of MULHSU are used as-is.
- CALC runs for 32 iterations, counted by a 5-bit counter that wraps 31→0 and ends CALC.
  - Multiply: 64-bit accumulator; add the multiplicand if the LSB of the multiplier is 1, then shift right.
  - Divide: shift the {remainder, quotient} pair left, trial-subtract the divisor, and set the quotient bit when no borrow.
- FIX:
  - Negate the product or quotient if its sign is negative.
  - The remainder takes the sign of the dividend.
  - Result selection: MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits; DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide by zero: quotient = 0xFFFFFFFF and remainder = dividend, for both signed and unsigned.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV = 0x80000000, REM = 0.
- All arithmetic is modulo 2^32 (2^64 for the product). No exceptions are raised.
- `flush` in any non-IDLE state forces IDLE at the next edge.
  - `done` does not assert and `result` keeps its previous value.
  - `flush` together with `start` in IDLE means the start is not accepted.
- Reset (also mid-operation) forces: state IDLE, `busy`=0, `stall`=0, `done`=0, `result`=0, counter=0, internal registers=0.

## Timing
- Start accepted in cycle 0.
  - PREP: cycle 1.
  - CALC: cycles 2–33.
  - FIX: cycle 34.
  - DONE: cycle 35, with `done`=1 and `result` valid.
  - IDLE again at cycle 36.
- The earliest next accepted start is cycle 36.
- `stall` is combinational from `start` in cycle 0. It is registered (from state) afterwards, and drops in cycle 36.
- `result` is registered and updates only on the FIX→DONE edge.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - Divide-by-zero, signed overflow, and any op with an operand equal to 0 go PREP → DONE directly.
  - `done` then asserts in cycle 2 with the architectural result.
- Not defined: every op takes the full 35-cycle path, and the special cases are resolved in FIX.

## Structure
- Package `muldiv_pkg` holds:
  - the state enum (IDLE, PREP, CALC, FIX, DONE);
  - 3-bit op constants (OP_MUL…OP_REMU);
  - the SEL_MDIV_PREFIX constant 2'b11;
  - the SEL_IDLE constant 5'b10000;
  - the iteration count 32.
- Sub-module `muldiv_iter_core` holds the accumulator, shift/subtract step and counter.
  - The top level keeps the FSM, handshake, sign logic and result mux.

## Test plan
- MUL 7×6 (sel 24) → `done` in cycle 35, `result`=42, `busy` high in cycles 1–35.
- MULH 0x80000000×0x80000000 (sel 25) → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF (sel 27) → 0xFFFFFFFE.
- DIV −7/2 (sel 28) → 0xFFFFFFFD (−3); REM −7/2 (sel 30) → 0xFFFFFFFF (−1).
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - With `MULDIV_EARLY_OUT_EN`, each of these has `done` in cycle 2.
- `flush` in cycle 10 of a DIV → IDLE at cycle 11, no `done` pulse, `result` unchanged.
  - `start` with sel 16 → ignored, `busy` stays 0.
- `rst_n` low in cycle 20 of a MUL → all outputs 0 next cycle; a new MUL then completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared state encoding, RV32M op codes and sequencing constants for the
// multiply/divide sequencer.
package muldiv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [1:0] SEL_MDIV_PREFIX = 2'b11;
   localparam logic [4:0] SEL_IDLE        = 5'b10000;

   localparam int ITER_COUNT = 32;

endpackage

// File: rtl/muldiv_if.sv
// Handshake and data bundle between ALU control and the multiply/divide
// sequencer; the sequencer takes the slave side.
interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [4:0]      sel_operation;
   logic            flush;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic            busy;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, sel_operation, flush, operand_a, operand_b,
      input  busy, stall, done, result
   );

   modport slave (
      input  start, sel_operation, flush, operand_a, operand_b,
      output busy, stall, done, result
   );
endinterface

// File: rtl/muldiv_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply or restoring divide on a
// {hi, lo} register pair, one bit per step, with the iteration counter.
module muldiv_iter_core
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_step,
   input  logic            i_is_div,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo,
   output logic            o_last
);
   localparam int CNT_W = $clog2(ITER_COUNT);

   logic [XLEN-1:0]  r_hi;
   logic [XLEN-1:0]  r_lo;
   logic [XLEN-1:0]  r_op_b;
   logic [CNT_W-1:0] r_cnt;

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_shift;
   logic [XLEN-1:0] w_diff;
   logic            w_ge;

   // Multiply: hi accumulates, lo holds the multiplier and fills with product
   // bits. Divide: hi is the partial remainder, lo shifts dividend out and
   // quotient bits in.
   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op_b} : '0);
      w_shift = {r_hi, r_lo[XLEN-1]};
      w_ge    = w_shift >= {1'b0, r_op_b};
      w_diff  = w_shift[XLEN-1:0] - r_op_b;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_op_b <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_hi   <= '0;
         r_lo   <= i_op_a;
         r_op_b <= i_op_b;
         r_cnt  <= '0;
      end else if (i_step) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (i_is_div) begin
            r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_ge};
         end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
         end
      end
   end

   assign o_hi   = r_hi;
   assign o_lo   = r_lo;
   assign o_last = (r_cnt == CNT_W'(ITER_COUNT - 1));
endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: FSM, handshake, sign handling and result mux.
// Define MULDIV_EARLY_OUT_EN to skip CALC/FIX for zero operands, /0 and overflow.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  io_md
);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t          r_state, w_next;
   logic [2:0]      r_op;
   logic [XLEN-1:0] r_a, r_b, r_result;
   logic            r_neg_res;

   logic            w_accept, w_load, w_step, w_last, w_early;
   logic            w_is_div, w_rem_op, w_neg_a, w_neg_b, w_neg_res;
   logic            w_div_zero, w_overflow, w_special;
   logic [XLEN-1:0] w_mag_a, w_mag_b, w_hi, w_lo;
   logic [XLEN-1:0] w_quo_s, w_rem_s, w_special_result, w_fix_result, w_res_sel;
   logic [2*XLEN-1:0] w_prod_s;

   assign w_accept = io_md.start && (r_state == IDLE) && !io_md.flush &&
                     (io_md.sel_operation[4:3] == SEL_MDIV_PREFIX);

   assign w_is_div  = r_op[2];
   assign w_rem_op  = (r_op == OP_REM) || (r_op == OP_REMU);
   assign w_neg_a   = r_a[XLEN-1] && (r_op == OP_MULH || r_op == OP_MULHSU ||
                                      r_op == OP_DIV  || r_op == OP_REM);
   assign w_neg_b   = r_b[XLEN-1] && (r_op == OP_MULH || r_op == OP_DIV ||
                                      r_op == OP_REM);
   assign w_mag_a   = w_neg_a ? -r_a : r_a;
   assign w_mag_b   = w_neg_b ? -r_b : r_b;
   assign w_neg_res = w_rem_op ? w_neg_a : (w_neg_a ^ w_neg_b);

   // Architectural special cases are resolved from the raw operands.
   assign w_div_zero = w_is_div && (r_b == '0);
   assign w_overflow = (r_op == OP_DIV || r_op == OP_REM) &&
                       (r_a == MIN_NEG) && (r_b == '1);
   assign w_special  = w_div_zero || w_overflow || (r_a == '0) || (r_b == '0);

   always_comb begin
      w_special_result = '0;
      if (w_div_zero)      w_special_result = w_rem_op ? r_a : '1;
      else if (w_overflow) w_special_result = w_rem_op ? '0 : MIN_NEG;
   end

`ifdef MULDIV_EARLY_OUT_EN
   assign w_early = w_special;
`else
   assign w_early = 1'b0;
`endif

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_is_div (w_is_div),
      .i_op_a   (w_mag_a),
      .i_op_b   (w_mag_b),
      .o_hi     (w_hi),
      .o_lo     (w_lo),
      .o_last   (w_last)
   );

   assign w_prod_s = r_neg_res ? -{w_hi, w_lo} : {w_hi, w_lo};
   assign w_quo_s  = r_neg_res ? -w_lo : w_lo;
   assign w_rem_s  = r_neg_res ? -w_hi : w_hi;

   always_comb begin
      case (r_op)
         OP_MUL:                       w_fix_result = w_prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              w_fix_result = w_quo_s;
         default:                      w_fix_result = w_rem_s;
      endcase
   end

   assign w_res_sel = w_special ? w_special_result : w_fix_result;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // NOTE: every output of this block gets a default first so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_step = 1'b0;
      case (r_state)
         IDLE: if (w_accept) w_next = PREP;
         PREP: begin
            w_load = 1'b1;
            w_next = w_early ? DONE : CALC;
         end
         CALC: begin
            w_step = 1'b1;
            if (w_last) w_next = FIX;
         end
         FIX:     w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (io_md.flush && r_state != IDLE) w_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_neg_res <= 1'b0;
         r_result  <= '0;
      end else begin
         if (w_accept) begin
            r_op <= io_md.sel_operation[2:0];
            r_a  <= io_md.operand_a;
            r_b  <= io_md.operand_b;
         end
         if (r_state == PREP) r_neg_res <= w_neg_res;
         if (w_next == DONE && r_state != DONE) r_result <= w_res_sel;
      end
   end

   assign io_md.busy   = (r_state != IDLE);
   assign io_md.stall  = (r_state != IDLE) || w_accept;
   assign io_md.done   = (r_state == DONE);
   assign io_md.result = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M corner cases, flush,
// reset and randomized ops against an arithmetic reference model.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] exp_result_q = '0;

   muldiv_if #(.XLEN(32)) md ();

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io_md (md)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] sa, sb, sp;
      logic [63:0]        ua, ub, up;
      logic signed [31:0] sa32, sb32, sq;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      sa32 = a;
      sb32 = b;
      case (op)
         OP_MUL:    begin up = ua * ub;          return up[31:0];  end
         OP_MULH:   begin sp = sa * sb;          return sp[63:32]; end
         OP_MULHSU: begin sp = sa * $signed(ub); return sp[63:32]; end
         OP_MULHU:  begin up = ua * ub;          return up[63:32]; end
         OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            sq = sa32 / sb32;
            return sq;
         end
         OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            sq = sa32 % sb32;
            return sq;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
      return (op >= OP_DIV && b == 0) || a == 0 || b == 0 ||
             ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   // Drives one op and follows it to completion; poke_busy raises a stray
   // start with different operands in cycle 5, which must be ignored.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke_busy);
      logic [31:0] exp;
      int          exp_lat, cyc;
      bit          seen, busy_ok;
      exp     = ref_result(op, a, b);
      exp_lat = (EARLY_EN && is_special(op, a, b)) ? 2 : 35;
      @(negedge clk);
      md.start         = 1'b1;
      md.sel_operation = {SEL_MDIV_PREFIX, op};
      md.operand_a     = a;
      md.operand_b     = b;
      #1;
      check({name, "_c0_stall_busy"}, {30'b0, md.stall, md.busy}, 32'h2);
      cyc     = 0;
      seen    = 1'b0;
      busy_ok = 1'b1;
      while (!seen && cyc < 60) begin
         @(negedge clk);
         cyc++;
         md.start = poke_busy && cyc == 5;
         if (poke_busy && cyc == 5) begin
            md.sel_operation = {SEL_MDIV_PREFIX, ~op};
            md.operand_a     = ~a;
         end
         #1;
         if (!md.busy || !md.stall) busy_ok = 1'b0;
         if (md.done) seen = 1'b1;
      end
      md.start = 1'b0;
      check({name, "_latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
      check({name, "_result"}, md.result, exp);
      check({name, "_busy_run"}, {31'b0, busy_ok}, 32'h1);
      exp_result_q = exp;
      @(negedge clk);
      #1;
      check({name, "_idle_after"}, {29'b0, md.busy, md.stall, md.done}, 32'h0);
      check({name, "_result_held"}, md.result, exp_result_q);
   endtask

   // Starts an op and kills it at cycle `at` with flush or reset.
   task automatic run_abort(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int at, input bit use_reset);
      bit saw_done;
      @(negedge clk);
      md.start         = 1'b1;
      md.sel_operation = {SEL_MDIV_PREFIX, op};
      md.operand_a     = a;
      md.operand_b     = b;
      for (int c = 1; c <= at; c++) begin
         @(negedge clk);
         md.start = 1'b0;
      end
      #1;
      check({name, "_busy_before"}, {31'b0, md.busy}, 32'h1);
      if (use_reset) rst_n = 1'b0;
      else           md.flush = 1'b1;
      @(negedge clk);
      rst_n    = 1'b1;
      md.flush = 1'b0;
      if (use_reset) exp_result_q = '0;
      #1;
      check({name, "_outs_after"}, {29'b0, md.busy, md.stall, md.done}, 32'h0);
      check({name, "_result_after"}, md.result, exp_result_q);
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (md.done || md.busy) saw_done = 1'b1;
      end
      check({name, "_no_done"}, {31'b0, saw_done}, 32'h0);
   endtask

   task automatic try_ignored(input string name, input logic [4:0] sel, input bit with_flush);
      @(negedge clk);
      md.start         = 1'b1;
      md.sel_operation = sel;
      md.flush         = with_flush;
      md.operand_a     = 32'd9;
      md.operand_b     = 32'd3;
      #1;
      check({name, "_stall"}, {31'b0, md.stall}, 32'h0);
      @(negedge clk);
      md.start = 1'b0;
      md.flush = 1'b0;
      #1;
      check({name, "_busy"}, {31'b0, md.busy}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      md.start         = 1'b0;
      md.sel_operation = SEL_IDLE;
      md.flush         = 1'b0;
      md.operand_a     = '0;
      md.operand_b     = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_outs", {29'b0, md.busy, md.stall, md.done}, 32'h0);
      check("reset_result", md.result, 32'h0);
      rst_n = 1'b1;

      run_op("mul_7x6",     OP_MUL,   32'd7,        32'd6,        1'b0);
      run_op("mulh_min",    OP_MULH,  32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op("mulhu_max",   OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("div_m7_2",    OP_DIV,   -32'sd7,      32'd2,        1'b1);
      run_op("rem_m7_2",    OP_REM,   -32'sd7,      32'd2,        1'b0);
      run_op("divu_5_0",    OP_DIVU,  32'd5,        32'd0,        1'b0);
      run_op("remu_5_0",    OP_REMU,  32'd5,        32'd0,        1'b0);
      run_op("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("div_neg_0",   OP_DIV,   -32'sd5,      32'd0,        1'b0);
      run_op("mulhsu_neg",  OP_MULHSU, -32'sd3,     32'hFFFF_FFFF, 1'b0);

      try_ignored("sel16",       SEL_IDLE,  1'b0);
      try_ignored("sel_prefix01", 5'b01100, 1'b0);
      try_ignored("start_flush", {SEL_MDIV_PREFIX, OP_DIVU}, 1'b1);

      run_abort("div_flush", OP_DIV, -32'sd7, 32'd2, 10, 1'b0);
      run_op("mul_after_flush", OP_MUL, 32'd12, 32'd11, 1'b0);
      run_abort("mul_reset", OP_MUL, 32'd7, 32'd6, 20, 1'b1);
      run_op("mul_after_reset", OP_MUL, 32'd7, 32'd6, 1'b0);

      for (int i = 0; i < 24; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, (i % 4) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
